// File: rtl/lsu_bram_port.sv
// lsu_bram_port: load/store unit between the execute stage and a word-wide,
// byte-enabled block RAM with a one-cycle synchronous read. Accesses that
// straddle a word boundary are issued as two beats (word W, then W+1 modulo
// the RAM depth). Load bytes are reassembled and sign/zero-extended.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. The response is a single-cycle resp_valid
// pulse. resp_rdata/resp_err stay stable until the next response is formed.
module lsu_bram_port #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B0   = 3'd1,
    S_B1   = 3'd2,
    S_FIN  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Request registers captured at accept
  logic              write_q, write_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  // Beat-0 read data held while beat 1 is in flight
  logic [31:0]       lo_q, lo_d;

  // Response registers
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Address bits above the RAM byte range are intentionally ignored
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Access decode derived from the captured request
  logic [1:0]        off;
  logic [ADDR_W-1:0] word;
  logic [2:0]        size;
  logic [3:0]        size_mask;
  logic              legal;
  logic              split;
  logic [7:0]        mask8;
  logic [63:0]       data64;

  // Size, legality, split detection and the 8-byte write window
  always_comb begin
    off  = addr_q[1:0];
    word = addr_q[ADDR_W+1:2];
    case (func3_q)
      3'd0, 3'd4: begin size = 3'd1; size_mask = 4'b0001; end
      3'd1, 3'd5: begin size = 3'd2; size_mask = 4'b0011; end
      default:    begin size = 3'd4; size_mask = 4'b1111; end
    endcase
    if (write_q) begin
      legal = (func3_q == 3'd0) || (func3_q == 3'd1) || (func3_q == 3'd2);
    end else begin
      legal = !((func3_q == 3'd3) || (func3_q == 3'd6) || (func3_q == 3'd7));
    end
    // Illegal requests are always single-beat
    split  = legal && (({2'b00, off} + {1'b0, size}) > 4'd4);
    mask8  = {4'b0000, size_mask} << off;
    data64 = {32'h0000_0000, wdata_q} << {off, 3'b000};
  end

  // Load reassembly: join both beats, shift the addressed byte down, extend
  logic [63:0] rd64;
  logic [63:0] sh64;
  logic [31:0] sh_unused_hi;
  logic [31:0] load_result;
  logic        sign_ext;

  // Build the extended load value from the last-beat RAM data and held beat 0
  always_comb begin
    rd64         = split ? {mem_rdata, lo_q} : {32'h0000_0000, mem_rdata};
    sh64         = rd64 >> {off, 3'b000};
    sh_unused_hi = sh64[63:32];
    sign_ext     = !func3_q[2];
    case (size)
      3'd1:    load_result = {{24{sign_ext & sh64[7]}}, sh64[7:0]};
      3'd2:    load_result = {{16{sign_ext & sh64[15]}}, sh64[15:0]};
      default: load_result = sh64[31:0];
    endcase
    if (write_q || !legal) begin
      load_result = 32'h0000_0000;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_B0;
      S_B0:    state_d = split ? S_B1 : S_FIN;
      S_B1:    state_d = S_FIN;
      S_FIN:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshake and RAM port decoded from state and captured request
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 4'b0000;
    mem_addr   = '0;
    mem_wdata  = 32'h0000_0000;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_B0: begin
        mem_en    = 1'b1;
        mem_addr  = word;
        mem_we    = (write_q && legal) ? mask8[3:0] : 4'b0000;
        mem_wdata = write_q ? data64[31:0] : 32'h0000_0000;
      end
      S_B1: begin
        mem_en    = 1'b1;
        mem_addr  = word + {{(ADDR_W-1){1'b0}}, 1'b1};
        mem_we    = (write_q && legal) ? mask8[7:4] : 4'b0000;
        mem_wdata = write_q ? data64[63:32] : 32'h0000_0000;
      end
      S_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath register updates: capture at accept, hold beat 0, form response
  always_comb begin
    write_d = write_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          func3_d = req_func3;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
        end
      end
      S_B1: begin
        if (!write_q) lo_d = mem_rdata;
      end
      S_FIN: begin
        rdata_d = load_result;
        err_d   = !legal;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      func3_q <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      lo_q    <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      write_q <= write_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule
